// File: rtl/mem_resp_stage_if.sv
// ---------------------------------------------------------------------------
// mem_resp_stage_if
//   Bundles every handshake and data signal of mem_resp_stage.
//   slave  : used by mem_resp_stage itself.
//   master : used by the surrounding pipeline (EX, data memory, WB, control).
//
//   EX side   : in_valid/in_ready, in_ex_result, in_ld_ctrl {ld_w,ld_b,ld_bu,
//               ld_h,ld_hu}, in_res_from_mem, in_rf_we, in_rf_waddr, in_pc
//   Memory    : data_ok, rdata (in-order load data, one word per pulse)
//   Control   : flush, busy
//   WB side   : out_valid/out_ready, out_result, out_rf_we, out_rf_waddr, out_pc
//   Optional  : bypass_bus {rf_waddr, rf_we & valid, result} when the macro
//               MEM_BYPASS_EN is defined.
// ---------------------------------------------------------------------------
interface mem_resp_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ex_result;
  logic [4:0]  in_ld_ctrl;
  logic        in_res_from_mem;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic [31:0] in_pc;

  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [31:0] out_pc;
  logic        busy;

`ifdef MEM_BYPASS_EN
  logic [37:0] bypass_bus;

  modport slave (
    input  in_valid, in_ex_result, in_ld_ctrl, in_res_from_mem,
           in_rf_we, in_rf_waddr, in_pc, data_ok, rdata, flush, out_ready,
    output in_ready, out_valid, out_result, out_rf_we, out_rf_waddr,
           out_pc, busy, bypass_bus
  );

  modport master (
    output in_valid, in_ex_result, in_ld_ctrl, in_res_from_mem,
           in_rf_we, in_rf_waddr, in_pc, data_ok, rdata, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rf_we, out_rf_waddr,
           out_pc, busy, bypass_bus
  );
`else
  modport slave (
    input  in_valid, in_ex_result, in_ld_ctrl, in_res_from_mem,
           in_rf_we, in_rf_waddr, in_pc, data_ok, rdata, flush, out_ready,
    output in_ready, out_valid, out_result, out_rf_we, out_rf_waddr,
           out_pc, busy
  );

  modport master (
    output in_valid, in_ex_result, in_ld_ctrl, in_res_from_mem,
           in_rf_we, in_rf_waddr, in_pc, data_ok, rdata, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rf_we, out_rf_waddr,
           out_pc, busy
  );
`endif
endinterface

// File: rtl/mem_resp_stage.sv
// ---------------------------------------------------------------------------
// mem_resp_stage
//   Memory-response stage of the pipeline. Holds up to DEPTH in-flight
//   entries in a circular FIFO. ALU entries are complete on entry; load
//   entries wait for their in-order data_ok/rdata, which is lane-extracted
//   on capture so the stored result is final. The head entry drives the WB
//   side combinationally. flush drops all entries and remembers how many
//   load responses are still owed by memory (discard_cnt) so they can be
//   swallowed when they arrive.
//
//   Parameters : DEPTH  in-flight entries, power of two in 2..8
//   Ports      : clk    rising-edge clock
//                resetn asynchronous active-low reset
//                bus    mem_resp_stage_if.slave (see interface file)
//   Macro      : MEM_BYPASS_EN adds bus.bypass_bus = {rf_waddr,
//                rf_we & out_valid, result} of the head entry.
// ---------------------------------------------------------------------------
module mem_resp_stage #(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  mem_resp_stage_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Load lane extraction; ctrl = {ld_w, ld_b, ld_bu, ld_h, ld_hu}.
  function automatic logic [31:0] ld_extract(input logic [31:0] word,
                                             input logic [4:0]  ctrl,
                                             input logic [1:0]  addr);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic        [31:0] r;
    lane_b = word[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? word[31:16] : word[15:0];
    if (ctrl[4])      r = word;
    else if (ctrl[3]) r = 32'(lane_b);
    else if (ctrl[2]) r = {24'd0, lane_b};
    else if (ctrl[1]) r = 32'(lane_h);
    else if (ctrl[0]) r = {16'd0, lane_h};
    else              r = word;
    return r;
  endfunction

  // Entry storage (data, not reset).
  logic [31:0]      res_q   [DEPTH];
  logic [4:0]       ctrl_q  [DEPTH];
  logic [4:0]       waddr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [DEPTH-1:0] we_q;

  // Control state.
  logic [DEPTH-1:0] done_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    discard_cnt;

  logic             in_rdy;
  logic             out_vld;
  logic             push;
  logic             pop;
  logic             resp_found;
  logic [PW-1:0]    resp_idx;
  logic [CW-1:0]    pend_cnt;
  logic             resp_wr;
  logic             resp_drop;
  logic [CW-1:0]    owed;

  // Loads complete in order, so the oldest incomplete occupied slot is the
  // response pointer, and the number of incomplete slots is the number of
  // responses memory still owes for live entries.
  always_comb begin
    logic [PW-1:0] scan_idx;
    scan_idx   = rd_ptr;
    resp_found = 1'b0;
    resp_idx   = rd_ptr;
    pend_cnt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && !done_q[scan_idx]) begin
        if (!resp_found) begin
          resp_found = 1'b1;
          resp_idx   = scan_idx;
        end
        pend_cnt = pend_cnt + CW'(1);
      end
    end
  end

  assign in_rdy  = (count < CW'(DEPTH)) && (discard_cnt == '0) && !bus.flush;
  assign out_vld = (count != '0) && done_q[rd_ptr];
  assign push    = bus.in_valid && in_rdy;
  assign pop     = out_vld && bus.out_ready;

  // Responses owed from before a flush are older than any live load, so
  // they are consumed first. A data_ok with nothing owed is ignored.
  assign resp_wr   = bus.data_ok && !bus.flush && (discard_cnt == '0) && resp_found;
  assign resp_drop = bus.data_ok && !bus.flush && (discard_cnt != '0);

  // Responses still owed after a flush; a data_ok in the flush cycle pays
  // one of them off.
  always_comb begin
    owed = discard_cnt + pend_cnt;
    if (bus.data_ok && (owed != '0))
      owed = owed - CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      discard_cnt <= '0;
      done_q      <= '0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      done_q      <= '0;
      discard_cnt <= owed;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PW'(1);
        done_q[wr_ptr] <= !bus.in_res_from_mem;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PW'(1);
        done_q[rd_ptr] <= 1'b0;
      end
      if (resp_wr)
        done_q[resp_idx] <= 1'b1;
      if (resp_drop)
        discard_cnt <= discard_cnt - CW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Push and response target distinct slots: the response slot is occupied
  // and incomplete, the push slot is free.
  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr]   <= bus.in_ex_result;
      ctrl_q[wr_ptr]  <= bus.in_ld_ctrl;
      waddr_q[wr_ptr] <= bus.in_rf_waddr;
      pc_q[wr_ptr]    <= bus.in_pc;
      we_q[wr_ptr]    <= bus.in_rf_we;
    end
    if (resp_wr)
      res_q[resp_idx] <= ld_extract(bus.rdata, ctrl_q[resp_idx], res_q[resp_idx][1:0]);
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = out_vld;
  assign bus.out_result   = res_q[rd_ptr];
  assign bus.out_rf_we    = we_q[rd_ptr];
  assign bus.out_rf_waddr = waddr_q[rd_ptr];
  assign bus.out_pc       = pc_q[rd_ptr];
  assign bus.busy         = (count != '0) || (discard_cnt != '0);

`ifdef MEM_BYPASS_EN
  assign bus.bypass_bus = {waddr_q[rd_ptr], we_q[rd_ptr] & out_vld, res_q[rd_ptr]};
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_resp_stage
//   Directed scenarios plus randomized traffic for mem_resp_stage, checked
//   against a queue-based reference model of in-flight entries.
// ---------------------------------------------------------------------------
module tb_mem_resp_stage;

  localparam int DEPTH = 2;

  localparam logic [4:0] LD_W  = 5'b10000;
  localparam logic [4:0] LD_B  = 5'b01000;
  localparam logic [4:0] LD_BU = 5'b00100;
  localparam logic [4:0] LD_H  = 5'b00010;
  localparam logic [4:0] LD_HU = 5'b00001;

  logic clk;
  logic resetn;

  mem_resp_stage_if bus();

  mem_resp_stage #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    logic [4:0]  ctrl;
    logic [31:0] exr;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] pc;
    bit          done;
    logic [31:0] res;
  } ent_t;

  ent_t mq[$];
  int   disc;

  int n_checks;
  int n_errors;

  logic        obs_valid;
  logic        obs_rdy;
  logic        obs_busy;
  logic [31:0] obs_result;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load extraction from byte/halfword arithmetic.
  function automatic logic [31:0] mext(input logic [31:0] w, input logic [4:0] c,
                                       input logic [1:0] a);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (c)
      LD_B:    return (b >= 128) ? b - 256 : b;
      LD_BU:   return b;
      LD_H:    return (h >= 32768) ? h - 65536 : h;
      LD_HU:   return h;
      default: return w;
    endcase
  endfunction

  // One clock of stimulus: drive before the edge, compare the model's view
  // of the current state, then advance the model at the edge.
  task automatic step(input bit iv, input bit ld, input logic [4:0] ctrl,
                      input logic [31:0] exr, input bit dok, input logic [31:0] rd,
                      input bit fl, input bit ordy);
    ent_t e;
    bit   exp_v;
    bit   exp_rdy;
    bit   fire;
    bit   popd;
    int   pend;
    @(negedge clk);
    bus.in_valid        = iv;
    bus.in_res_from_mem = ld;
    bus.in_ld_ctrl      = ctrl;
    bus.in_ex_result    = exr;
    bus.in_rf_we        = 1'($urandom);
    bus.in_rf_waddr     = 5'($urandom);
    bus.in_pc           = $urandom;
    bus.data_ok         = dok;
    bus.rdata           = rd;
    bus.flush           = fl;
    bus.out_ready       = ordy;
    #1;
    exp_v   = (mq.size() != 0) && mq[0].done;
    exp_rdy = (mq.size() < DEPTH) && (disc == 0) && !fl;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("busy", 32'(bus.busy), 32'((mq.size() != 0) || (disc != 0)));
    if (exp_v) begin
      chk("out_result", bus.out_result, mq[0].res);
      chk("out_rf_we", 32'(bus.out_rf_we), 32'(mq[0].we));
      chk("out_rf_waddr", 32'(bus.out_rf_waddr), 32'(mq[0].wa));
      chk("out_pc", bus.out_pc, mq[0].pc);
`ifdef MEM_BYPASS_EN
      chk("bypass", bus.bypass_bus[31:0], mq[0].res);
      chk("bypass_we", 32'(bus.bypass_bus[32]), 32'(mq[0].we));
      chk("bypass_wa", 32'(bus.bypass_bus[37:33]), 32'(mq[0].wa));
`endif
    end
    obs_valid  = bus.out_valid;
    obs_rdy    = bus.in_ready;
    obs_busy   = bus.busy;
    obs_result = bus.out_result;
    fire = iv && exp_rdy;
    popd = exp_v && ordy;
    e.ld   = ld;
    e.ctrl = ctrl;
    e.exr  = exr;
    e.we   = bus.in_rf_we;
    e.wa   = bus.in_rf_waddr;
    e.pc   = bus.in_pc;
    e.done = !ld;
    e.res  = exr;
    @(posedge clk);
    if (fl) begin
      pend = 0;
      foreach (mq[i]) if (!mq[i].done) pend++;
      pend = pend + disc;
      if (dok && pend > 0) pend--;
      disc = pend;
      mq.delete();
    end else begin
      if (dok) begin
        if (disc > 0) begin
          disc--;
        end else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].done) begin
              mq[i].done = 1'b1;
              mq[i].res  = mext(rd, mq[i].ctrl, mq[i].exr[1:0]);
              break;
            end
          end
        end
      end
      if (popd) void'(mq.pop_front());
      if (fire) mq.push_back(e);
    end
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 5'd0, 32'd0, 0, 32'd0, 0, ordy);
  endtask

  task automatic push(input bit ld, input logic [4:0] ctrl, input logic [31:0] exr);
    step(1, ld, ctrl, exr, 0, 32'd0, 0, 0);
  endtask

  task automatic resp(input logic [31:0] rd);
    step(0, 0, 5'd0, 32'd0, 1, rd, 0, 0);
  endtask

  task automatic load_case(input string tag, input logic [4:0] ctrl, input logic [1:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
    push(1, ctrl, {30'h0000_0400, a});
    resp(rd);
    idle(1);
    chk(tag, obs_result, exp);
  endtask

  initial begin
    logic [4:0] lds [5];
    lds[0] = LD_W; lds[1] = LD_B; lds[2] = LD_BU; lds[3] = LD_H; lds[4] = LD_HU;
    n_checks = 0;
    n_errors = 0;
    disc     = 0;
    resetn   = 1'b0;
    bus.in_valid = 0; bus.in_res_from_mem = 0; bus.in_ld_ctrl = 0; bus.in_ex_result = 0;
    bus.in_rf_we = 0; bus.in_rf_waddr = 0; bus.in_pc = 0;
    bus.data_ok = 0; bus.rdata = 0; bus.flush = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // ALU entry appears at the head with no added latency.
    step(1, 0, 5'd0, 32'h0000_1234, 0, 32'd0, 0, 1);
    idle(1);
    chk("alu_valid", 32'(obs_valid), 32'd1);
    chk("alu_result", obs_result, 32'h0000_1234);

    // Lane extraction.
    load_case("ld_b", LD_B, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
    load_case("ld_bu", LD_BU, 2'd3, 32'h80FF_0000, 32'h0000_0080);
    load_case("ld_hu", LD_HU, 2'd2, 32'h80FF_0000, 32'h0000_80FF);
    load_case("ld_h", LD_H, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF);
    load_case("ld_w", LD_W, 2'd0, 32'h80FF_0000, 32'h80FF_0000);
    load_case("ld_b0", LD_B, 2'd0, 32'h1234_567F, 32'h0000_007F);

    // Fill to DEPTH, responses kept in order, then drain.
    push(1, LD_W, 32'h0000_0100);
    push(1, LD_W, 32'h0000_0104);
    idle(0);
    chk("full_in_ready", 32'(obs_rdy), 32'd0);
    resp(32'hAAAA_0001);
    resp(32'hBBBB_0002);
    idle(1);
    chk("order_first", obs_result, 32'hAAAA_0001);
    idle(1);
    chk("order_second", obs_result, 32'hBBBB_0002);
    idle(1);
    chk("drained", 32'(obs_valid), 32'd0);

    // Flush with two pending loads and a simultaneous response.
    push(1, LD_W, 32'h0000_0200);
    push(1, LD_W, 32'h0000_0204);
    step(0, 0, 5'd0, 32'd0, 1, 32'h1111_1111, 1, 0);
    idle(0);
    chk("flush_in_ready", 32'(obs_rdy), 32'd0);
    chk("flush_busy", 32'(obs_busy), 32'd1);
    resp(32'h2222_2222);
    idle(0);
    chk("discard_in_ready", 32'(obs_rdy), 32'd1);
    chk("discard_busy", 32'(obs_busy), 32'd0);

    // ALU entry stays behind a pending load.
    step(1, 1, LD_W, 32'h0000_0300, 0, 32'd0, 0, 1);
    step(1, 0, 5'd0, 32'h0000_0055, 0, 32'd0, 0, 1);
    idle(1);
    chk("blocked_valid", 32'(obs_valid), 32'd0);
    step(0, 0, 5'd0, 32'd0, 1, 32'hCAFE_F00D, 0, 1);
    idle(1);
    chk("inorder_load", obs_result, 32'hCAFE_F00D);
    idle(1);
    chk("inorder_alu", obs_result, 32'h0000_0055);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          iv, ld, dok, fl, ordy;
      logic [4:0]  c;
      int          pend;
      pend = 0;
      foreach (mq[i]) if (!mq[i].done) pend++;
      iv   = ($urandom_range(0, 99) < 60);
      ld   = ($urandom_range(0, 99) < 50);
      c    = ld ? lds[$urandom_range(0, 4)] : 5'($urandom);
      fl   = ($urandom_range(0, 99) < 3);
      ordy = ($urandom_range(0, 99) < 70);
      if (pend > 0 || disc > 0) dok = ($urandom_range(0, 99) < 45);
      else                      dok = ($urandom_range(0, 99) < 2);
      step(iv, ld, c, $urandom, dok, $urandom, fl, ordy);
    end

    // Asynchronous reset with two entries held.
    idle(1);
    idle(1);
    push(0, 5'd0, 32'h0000_0AAA);
    push(0, 5'd0, 32'h0000_0BBB);
    idle(0);
    chk("held_valid", 32'(obs_valid), 32'd1);
    @(negedge clk);
    bus.in_valid = 0;
    bus.data_ok  = 0;
    bus.flush    = 0;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    mq.delete();
    disc = 0;
    @(negedge clk);
    resetn = 1'b1;
    idle(1);
    chk("post_rst_in_ready", 32'(obs_rdy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
